mips_instr_encoder: RTL and testbench
=====================================

# mips_instr_encoder

Streaming instruction encoder and loader: the inverse of the core's control decoder. It accepts symbolic instruction commands (mnemonic plus operand fields) over a valid/ready handshake, packs each into a 32-bit MIPS word using the same opcode/funct assignments the decoder recognises, and writes the words sequentially into instruction memory. It sits on the boot/debug path ahead of the pipeline's instruction RAM and is used to load test programs without an external assembler.

## Interface
- ADDR_W, default 10: instruction memory word-address width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a load session at base_addr.
- base_addr  in  ADDR_W  first word address, sampled on start.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_mnem  in  5  mnemonic code (enc_pkg enum).
- in_rs / in_rt / in_rd / in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target.
- in_last  in  1  marks the final command of the session.
- mem_we  out  1  write request; held until mem_ready.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  state is RUN.
- done  out  1  level; session complete.
- err_illegal  out  1  sticky; an illegal mnemonic was dropped.
- wrapped  out  1  sticky; address counter wrapped past all-ones.
- word_count  out  ADDR_W+1  words written this session.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE; every output 0, and the address counter is 0.
- IDLE/DONE to RUN on start. This loads the address counter from base_addr and clears word_count, done, err_illegal, wrapped, and checksum. start is ignored in RUN.
- RUN to DONE when the write of the in_last command completes (mem_we && mem_ready). done is asserted in DONE.
- If the last command is illegal, the transition to DONE happens at acceptance.
- in_ready = busy && (!mem_we || mem_ready). A single output register is used; no skid buffer.
- Encoding:
  - R-type: {0, rs, rt, rd, shamt, funct}.
  - SLL/SRA/SRL force rs=0.
  - JR keeps only rs.
  - SYSCALL is 0x0000000C.
  - J/JAL: {op, target}.
  - I-type: {op, rs, rt, imm}.
  - BLTZ forces rt=0.
- Opcodes: J 2, JAL 3, BEQ 4, BNE 5, ADDI 8, ADDIU 9, SLTI 10, SLTIU 11, ANDI 12, ORI 13, XORI 14, LH 33, LW 35, SW 43, BLTZ 1.
- Functs: SLL 0, SRL 2, SRA 3, JR 8, SYSCALL 12, ADD 32, ADDU 33, SUB 34, AND 36, OR 37, NOR 39, SLT 42, SLTU 43.
- Mnemonic codes 28–31 are illegal. An illegal command is accepted and consumed, but not written; it sets err_illegal, and neither the address nor the count advances.
- Address counter wraps modulo 2^ADDR_W. Wrapping sets wrapped; writing continues.
- Asserting rst_n low mid-session aborts any pending write immediately; all state returns to reset values.

## Timing
- Accept at edge N: mem_we, mem_addr, and mem_wdata are valid from N+1 and held stable until the edge where mem_ready=1.
- Back-to-back: with mem_ready tied high, one word is written per cycle.
- Acceptance and completion on the same edge: the old word retires, and the new word loads at that edge.
- The address counter and word_count update on the completion edge.
- done rises one cycle after the last completion edge.

## Configuration
- ENC_CHECKSUM_EN defined: adds output checksum (32 bits), the XOR of all words written this session. It is cleared on start and on reset, and updated on each completion edge.
- ENC_CHECKSUM_EN not defined: no port and no logic.

## Structure
- enc_pkg holds:
  - the 5-bit mnemonic enum, with values 0–27 in the order SLL, SRA, SRL, ADD, ADDU, SUB, AND, OR, NOR, SLT, SLTU, JR, SYSCALL, J, JAL, BEQ, BNE, ADDI, ANDI, ADDIU, SLTI, ORI, LW, SW, XORI, SLTIU, LH, BLTZ;
  - opcode and funct localparams;
  - the state enum.
- Sub-module enc_pack: purely combinational mnemonic+fields to {word, illegal}. The top level holds the FSM, counters, and output register.

## Test plan
- ADD rs=1 rt=2 rd=3, base 0x010 → mem_wdata 0x00221820 at mem_addr 0x010, written one cycle after accept.
- SLL rt=1 rd=2 shamt=4 with in_rs=31; then ADDI rs=0 rt=8 imm=5 → 0x00011100, then 0x20080005; rs is forced to 0 for SLL.
- J target 0x0100000, BLTZ rs=4 imm=0xFFFE, SYSCALL (last), with mem_ready low for 3 cycles on the 2nd word → 0x08100000, 0x0480FFFE, 0x0000000C, written in order. Write data is held during the stall, word_count=3, and done=1.
- Mnemonic 30 between two legal commands → err_illegal=1, the two legal words go to consecutive addresses, and word_count=2.
- ADDR_W=4, base 0xE, 4 commands → addresses 0xE, 0xF, 0x0, 0x1 and wrapped=1. rst_n low during a stalled write → mem_we=0 and busy=0 immediately.
- ENC_CHECKSUM_EN: after the J/BLTZ/SYSCALL session, checksum = 0x08100000 ^ 0x0480FFFE ^ 0x0000000C = 0x0C90FFF2.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types for the MIPS instruction encoder: mnemonic codes, opcode/funct
// values matching the core's control decoder, session states and word packers.
package enc_pkg;

  localparam int unsigned MNEM_W = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [MNEM_W-1:0] {
    MN_SLL, MN_SRA, MN_SRL, MN_ADD, MN_ADDU, MN_SUB, MN_AND, MN_OR, MN_NOR,
    MN_SLT, MN_SLTU, MN_JR, MN_SYSCALL, MN_J, MN_JAL, MN_BEQ, MN_BNE, MN_ADDI,
    MN_ANDI, MN_ADDIU, MN_SLTI, MN_ORI, MN_LW, MN_SW, MN_XORI, MN_SLTIU, MN_LH,
    MN_BLTZ
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BLTZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LH    = 6'd33;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL     = 6'd0;
  localparam logic [5:0] FN_SRL     = 6'd2;
  localparam logic [5:0] FN_SRA     = 6'd3;
  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_SYSCALL = 6'd12;
  localparam logic [5:0] FN_ADD     = 6'd32;
  localparam logic [5:0] FN_ADDU    = 6'd33;
  localparam logic [5:0] FN_SUB     = 6'd34;
  localparam logic [5:0] FN_AND     = 6'd36;
  localparam logic [5:0] FN_OR      = 6'd37;
  localparam logic [5:0] FN_NOR     = 6'd39;
  localparam logic [5:0] FN_SLT     = 6'd42;
  localparam logic [5:0] FN_SLTU    = 6'd43;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  function automatic logic [WORD_W-1:0] r_word(input logic [REG_W-1:0] rs,
                                               input logic [REG_W-1:0] rt,
                                               input logic [REG_W-1:0] rd,
                                               input logic [REG_W-1:0] sh,
                                               input logic [5:0]       fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [WORD_W-1:0] i_word(input logic [5:0]       op,
                                               input logic [REG_W-1:0] rs,
                                               input logic [REG_W-1:0] rt,
                                               input logic [IMM_W-1:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/enc_pack.sv
// Combinational packer: mnemonic plus operand fields into a 32-bit MIPS word.
module enc_pack
  import enc_pkg::*;
(
  input  logic [MNEM_W-1:0] mnem_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [REG_W-1:0]  shamt_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [TGT_W-1:0]  target_i,
  output logic [WORD_W-1:0] word_o,
  output logic              illegal_o
);

  mnem_e mnem;
  assign mnem = mnem_e'(mnem_i);

  // Codes past MN_BLTZ fall into the default arm and are flagged illegal.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (mnem)
      MN_SLL:     word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
      MN_SRA:     word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRA);
      MN_SRL:     word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
      MN_ADD:     word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_ADD);
      MN_ADDU:    word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_ADDU);
      MN_SUB:     word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_SUB);
      MN_AND:     word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_AND);
      MN_OR:      word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_OR);
      MN_NOR:     word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_NOR);
      MN_SLT:     word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_SLT);
      MN_SLTU:    word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FN_SLTU);
      MN_JR:      word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_SYSCALL: word_o = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
      MN_J:       word_o = {OP_J, target_i};
      MN_JAL:     word_o = {OP_JAL, target_i};
      MN_BEQ:     word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
      MN_BNE:     word_o = i_word(OP_BNE, rs_i, rt_i, imm_i);
      MN_ADDI:    word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
      MN_ANDI:    word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
      MN_ADDIU:   word_o = i_word(OP_ADDIU, rs_i, rt_i, imm_i);
      MN_SLTI:    word_o = i_word(OP_SLTI, rs_i, rt_i, imm_i);
      MN_ORI:     word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
      MN_LW:      word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
      MN_SW:      word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
      MN_XORI:    word_o = i_word(OP_XORI, rs_i, rt_i, imm_i);
      MN_SLTIU:   word_o = i_word(OP_SLTIU, rs_i, rt_i, imm_i);
      MN_LH:      word_o = i_word(OP_LH, rs_i, rt_i, imm_i);
      MN_BLTZ:    word_o = i_word(OP_BLTZ, rs_i, 5'd0, imm_i);
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming instruction encoder/loader: symbolic commands in, packed words written
// sequentially to instruction RAM. Define ENC_CHECKSUM_EN for a running XOR checksum.
module mips_instr_encoder
  import enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MNEM_W-1:0] in_mnem,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_shamt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [TGT_W-1:0]  in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              wrapped,
  output logic [ADDR_W:0]   word_count
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] checksum
`endif
);

  state_e              state_q;
  logic                busy_q, done_q, err_q, wrap_q;
  logic                mem_we_q, last_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     cnt_q;
  logic [WORD_W-1:0]   pack_word;
  logic                pack_illegal;
  logic                accept_c, complete_c, launch_c;

  enc_pack u_pack (
    .mnem_i    (in_mnem),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .shamt_i   (in_shamt),
    .imm_i     (in_imm),
    .target_i  (in_target),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  assign in_ready    = busy_q && (!mem_we_q || mem_ready);
  assign accept_c    = in_valid && in_ready;
  assign complete_c  = mem_we_q && mem_ready;
  assign launch_c    = start && (state_q != S_RUN);

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_illegal = err_q;
  assign wrapped     = wrap_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign word_count  = cnt_q;

  // Session FSM; addr_q always holds the address of the pending/next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      mem_we_q <= 1'b0;
      last_q   <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            mem_we_q <= 1'b0;
            last_q   <= 1'b0;
            addr_q   <= base_addr;
            cnt_q    <= '0;
          end
        end
        S_RUN: begin
          if (complete_c) begin
            mem_we_q <= 1'b0;
            addr_q   <= addr_q + ADDR_W'(1);
            cnt_q    <= cnt_q + (ADDR_W+1)'(1);
            if (&addr_q) wrap_q <= 1'b1;
            if (last_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          // A new word may load on the same edge the previous one retires.
          if (accept_c) begin
            if (pack_illegal) begin
              err_q <= 1'b1;
              if (in_last) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              mem_we_q <= 1'b1;
              wdata_q  <= pack_word;
              last_q   <= in_last;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q;

  assign checksum = csum_q;

  // Running XOR of every word retired in the current session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (launch_c) begin
      csum_q <= '0;
    end else if (complete_c) begin
      csum_q <= csum_q ^ wdata_q;
    end
  end
`else
  logic unused_launch;
  assign unused_launch = launch_c;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus randomized
// sessions scored against a table-driven reference encoder and write scoreboard.
module tb_mips_instr_encoder;

  localparam int unsigned AW   = 10;
  localparam int unsigned AW_S = 4;
  localparam int FN_TAB [13] = '{0, 3, 2, 32, 33, 34, 36, 37, 39, 42, 43, 8, 12};
  localparam int OP_TAB [13] = '{4, 5, 8, 12, 9, 10, 13, 35, 43, 14, 11, 33, 1};

  typedef struct {
    logic [31:0] w;
    int          a;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic            in_valid = 1'b0;
  logic [4:0]      in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0]     in_imm = '0;
  logic [25:0]     in_target = '0;
  logic            in_last = 1'b0;
  logic            mem_ready = 1'b1;

  logic            in_ready, mem_we, busy, done, err_illegal, wrapped;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [AW:0]     word_count;

  logic            in_ready_s, mem_we_s, busy_s, done_s, err_illegal_s, wrapped_s;
  logic [AW_S-1:0] mem_addr_s;
  logic [31:0]     mem_wdata_s;
  logic [AW_S:0]   word_count_s;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]     checksum, checksum_s;
`endif

  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  int          m_addr = 0, m_count = 0;
  bit          m_err = 1'b0, m_wrap = 1'b0, m_wrap_s = 1'b0;
  logic [31:0] m_csum = '0;
  int          stall_left = 0;
  bit          hold_low = 1'b0, rnd_ready = 1'b0;
  int          lat;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err_illegal(err_illegal), .wrapped(wrapped), .word_count(word_count)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  mips_instr_encoder #(.ADDR_W(AW_S)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr[AW_S-1:0]),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_mnem(in_mnem), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .mem_ready(mem_ready), .busy(busy_s), .done(done_s),
    .err_illegal(err_illegal_s), .wrapped(wrapped_s), .word_count(word_count_s)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum_s)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder built from the opcode/funct tables with plain arithmetic.
  function automatic logic [31:0] ref_enc(input int m, input int rs, input int rt,
                                          input int rd, input int sh, input int imm,
                                          input int tgt, output bit ill);
    longint w;
    ill = 1'b0;
    w   = 0;
    if (m == 12) w = 12;
    else if (m == 11) w = longint'(rs) * 2097152 + 8;
    else if (m <= 10)
      w = longint'((m <= 2) ? 0 : rs) * 2097152 + longint'(rt) * 65536 +
          longint'(rd) * 2048 + longint'(sh) * 64 + longint'(FN_TAB[m]);
    else if (m <= 14) w = longint'(m - 11) * 67108864 + longint'(tgt);
    else if (m <= 27)
      w = longint'(OP_TAB[m-15]) * 67108864 + longint'(rs) * 2097152 +
          longint'((m == 27) ? 0 : rt) * 65536 + longint'(imm);
    else ill = 1'b1;
    return w[31:0];
  endfunction

  // One clock: drive mem_ready for the next edge, then score the write port.
  task automatic tick();
    @(negedge clk);
    if (hold_low) mem_ready = 1'b0;
    else if (stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else if (rnd_ready) mem_ready = ($urandom_range(0, 3) != 0);
    else mem_ready = 1'b1;
    #1;
    check("mem_we", 64'(mem_we), 64'(exp_q.size() > 0));
    if (mem_we && exp_q.size() > 0) begin
      check("wdata", 64'(mem_wdata), 64'(exp_q[0].w));
      check("addr", 64'(mem_addr), 64'(exp_q[0].a & 'h3FF));
      check("mem_we_s", 64'(mem_we_s), 64'(1));
      check("wdata_s", 64'(mem_wdata_s), 64'(exp_q[0].w));
      check("addr_s", 64'(mem_addr_s), 64'(exp_q[0].a & 'hF));
      if (mem_ready) void'(exp_q.pop_front());
    end
  endtask

  task automatic begin_session(input int b);
    start     = 1'b1;
    base_addr = AW'(b);
    m_addr    = b;
    m_count   = 0;
    m_err     = 1'b0;
    m_wrap    = 1'b0;
    m_wrap_s  = 1'b0;
    m_csum    = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int m, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input bit last);
    bit          ill;
    logic [31:0] w;
    int          n = 0;
    in_mnem   = 5'(m);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
    in_last   = last;
    in_valid  = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
    else begin
      w = ref_enc(m, rs, rt, rd, sh, imm, tgt, ill);
      if (ill) m_err = 1'b1;
      else begin
        if ((m_addr & 'h3FF) == 'h3FF) m_wrap = 1'b1;
        if ((m_addr & 'hF) == 'hF) m_wrap_s = 1'b1;
        exp_q.push_back('{w: w, a: m_addr});
        m_addr++;
        m_count++;
        m_csum ^= w;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic end_session(output int waited);
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    waited = n;
    check("done", 64'(done), 64'(1));
    check("busy_end", 64'(busy), 64'(0));
    check("in_ready_end", 64'(in_ready), 64'(0));
    check("we_end", 64'(mem_we), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("word_count", 64'(word_count), 64'(m_count));
    check("err_illegal", 64'(err_illegal), 64'(m_err));
    check("wrapped", 64'(wrapped), 64'(m_wrap));
    check("wrapped_s", 64'(wrapped_s), 64'(m_wrap_s));
    check("word_count_s", 64'(word_count_s), 64'(m_count));
`ifdef ENC_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(m_csum));
`endif
  endtask

  initial begin
    // Reset values.
    tick();
    tick();
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err_illegal), 64'(0));
    check("rst_wrap", 64'(wrapped), 64'(0));
    check("rst_count", 64'(word_count), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single ADD, written one cycle after accept; done one cycle after completion.
    begin_session('h010);
    send(3, 1, 2, 3, 0, 0, 0, 1'b1);
    check("add_we", 64'(mem_we), 64'(1));
    check("add_word", 64'(mem_wdata), 64'h00221820);
    check("add_addr", 64'(mem_addr), 64'h010);
    end_session(lat);
    check("done_latency", 64'(lat), 64'(1));

    // SLL ignores rs; ADDI follows back-to-back.
    begin_session('h100);
    send(0, 31, 1, 2, 4, 0, 0, 1'b0);
    check("sll_word", 64'(mem_wdata), 64'h00011100);
    send(17, 0, 8, 0, 0, 5, 0, 1'b1);
    check("addi_word", 64'(mem_wdata), 64'h20080005);
    end_session(lat);

    // J / BLTZ / SYSCALL with a three-cycle stall on the second word.
    begin_session('h020);
    send(13, 0, 0, 0, 0, 0, 'h0100000, 1'b0);
    check("j_word", 64'(mem_wdata), 64'h08100000);
    stall_left = 3;
    send(27, 4, 7, 0, 0, 'hFFFE, 0, 1'b0);
    check("bltz_word", 64'(mem_wdata), 64'h0480FFFE);
    send(12, 3, 3, 3, 3, 0, 0, 1'b1);
    check("syscall_word", 64'(mem_wdata), 64'h0000000C);
    end_session(lat);
    check("stall_count", 64'(word_count), 64'(3));
`ifdef ENC_CHECKSUM_EN
    check("checksum_lit", 64'(checksum), 64'h0C90FFF2);
`endif

    // Illegal mnemonic between two legal commands.
    begin_session('h040);
    send(7, 5, 6, 7, 0, 0, 0, 1'b0);
    send(30, 1, 2, 3, 0, 0, 0, 1'b0);
    send(8, 9, 10, 11, 0, 0, 0, 1'b1);
    end_session(lat);
    check("illegal_err", 64'(err_illegal), 64'(1));
    check("illegal_count", 64'(word_count), 64'(2));

    // Address wrap on the 4-bit instance.
    begin_session('h00E);
    for (int i = 0; i < 4; i++) send(4, i, i + 1, i + 2, 0, 0, 0, i == 3);
    end_session(lat);
    check("wrap_small", 64'(wrapped_s), 64'(1));
    check("wrap_large", 64'(wrapped), 64'(0));

    // Reset during a stalled write aborts it immediately.
    begin_session('h050);
    hold_low = 1'b1;
    send(3, 1, 1, 1, 0, 0, 0, 1'b0);
    tick();
    check("pre_abort_we", 64'(mem_we), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_we", 64'(mem_we), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ready", 64'(in_ready), 64'(0));
    check("abort_addr", 64'(mem_addr), 64'(0));
    check("abort_we_s", 64'(mem_we_s), 64'(0));
    exp_q.delete();
    tick();
    rst_n    = 1'b1;
    hold_low = 1'b0;
    tick();

    // Randomized sessions with random backpressure.
    for (int s = 0; s < 24; s++) begin
      int b, n, m;
      rnd_ready = s[0];
      b = (s % 4 == 3) ? 'h3FA + $urandom_range(0, 5) : $urandom_range(0, 1023);
      n = $urandom_range(1, 8);
      begin_session(b);
      for (int k = 0; k < n; k++) begin
        m = ($urandom_range(0, 7) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 27);
        send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863),
             k == n - 1);
      end
      end_session(lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
